// File: rtl/conv_control_mc_if.sv
// Handshake/bus bundle for the multi-channel 3x3 convolution controller.
// The master side supplies frame data and weights; the slave side returns results.
interface conv_control_mc_if #(
  parameter int CH     = 2,
  parameter int DATA_W = 16
);
  logic                      start;
  logic [CH*9*DATA_W-1:0]    weight;
  logic                      din_valid;
  logic [CH*DATA_W-1:0]      din;
  logic [DATA_W-1:0]         result;
  logic                      dout_valid;
  logic                      done;
  logic                      busy;

  modport master (
    output start, weight, din_valid, din,
    input  result, dout_valid, done, busy
  );

  modport slave (
    input  start, weight, din_valid, din,
    output result, dout_valid, done, busy
  );
endinterface

// File: rtl/conv_control_mc.sv
// Streaming valid-mode 3x3 convolution summed over CH channels, with per-channel
// line buffers, signed fixed-point rounding/saturation and a fixed 2-cycle latency.
module conv_control_mc #(
  parameter int CH     = 2,
  parameter int IMG_W  = 4,
  parameter int IMG_H  = 4,
  parameter int DATA_W = 16,
  parameter int FRAC   = 8
) (
  input  logic             clk,
  input  logic             rst,
  conv_control_mc_if.slave bus
);
  localparam int PW    = 2 * DATA_W;
  localparam int ACC_W = PW + $clog2(9 * CH);
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);
  localparam int NOUT  = (IMG_W - 2) * (IMG_H - 2);
  localparam int OW    = $clog2(NOUT + 1);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
  localparam logic [OW-1:0] OUT_LAST = OW'(NOUT - 1);

  localparam logic signed [ACC_W-1:0] RND     = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                    state_r;
  logic                      busy_r;
  logic [RW-1:0]             row_r;
  logic [CW-1:0]             col_r;
  logic                      v0_r;
  logic                      v1_r;
  logic                      dout_valid_r;
  logic                      done_r;
  logic [DATA_W-1:0]         result_r;
  logic [OW-1:0]             out_cnt_r;
  logic signed [DATA_W-1:0]  wt_r   [CH*9];
  logic signed [DATA_W-1:0]  lb0_r  [CH][IMG_W];
  logic signed [DATA_W-1:0]  lb1_r  [CH][IMG_W];
  logic signed [DATA_W-1:0]  win_r  [CH][3][3];
  logic signed [PW-1:0]      prod_r [CH*9];

  logic                      start_acc_s;
  logic                      accept_s;
  logic signed [ACC_W-1:0]   acc_s;
  logic signed [ACC_W-1:0]   sat_s;

  function automatic logic signed [ACC_W-1:0] round_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] r;
    r = (acc + RND) >>> FRAC;
    if (r > SAT_MAX) begin
      return SAT_MAX;
    end else if (r < SAT_MIN) begin
      return SAT_MIN;
    end else begin
      return r;
    end
  endfunction

  assign start_acc_s = (state_r == IDLE) && bus.start;
  assign accept_s    = (state_r == LOAD) && bus.din_valid;

  // Frame sequencing: weight capture, raster counters and window-complete flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      row_r   <= '0;
      col_r   <= '0;
      v0_r    <= 1'b0;
      for (int i = 0; i < CH*9; i++) begin
        wt_r[i] <= '0;
      end
    end else begin
      v0_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            for (int i = 0; i < CH*9; i++) begin
              wt_r[i] <= bus.weight[i*DATA_W +: DATA_W];
            end
            row_r   <= '0;
            col_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= LOAD;
          end
        end
        LOAD: begin
          if (bus.din_valid) begin
            v0_r <= (row_r >= ROW_TWO) && (col_r >= COL_TWO);
            if (col_r == COL_LAST) begin
              col_r <= '0;
              if (row_r == ROW_LAST) begin
                state_r <= DRAIN;
              end else begin
                row_r <= row_r + RW'(1);
              end
            end else begin
              col_r <= col_r + CW'(1);
            end
          end
        end
        DRAIN: begin
          if (done_r) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Line buffers and 3x3 windows; column 2 of each window holds the newest pixels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        for (int x = 0; x < IMG_W; x++) begin
          lb0_r[c][x] <= '0;
          lb1_r[c][x] <= '0;
        end
        for (int r = 0; r < 3; r++) begin
          for (int k = 0; k < 3; k++) begin
            win_r[c][r][k] <= '0;
          end
        end
      end
    end else if (accept_s) begin
      for (int c = 0; c < CH; c++) begin
        for (int r = 0; r < 3; r++) begin
          win_r[c][r][0] <= win_r[c][r][1];
          win_r[c][r][1] <= win_r[c][r][2];
        end
        win_r[c][0][2]     <= lb1_r[c][col_r];
        win_r[c][1][2]     <= lb0_r[c][col_r];
        win_r[c][2][2]     <= bus.din[c*DATA_W +: DATA_W];
        lb1_r[c][col_r]    <= lb0_r[c][col_r];
        lb0_r[c][col_r]    <= bus.din[c*DATA_W +: DATA_W];
      end
    end
  end

  // Stage 1: full-precision products of the completed window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r <= 1'b0;
      for (int i = 0; i < CH*9; i++) begin
        prod_r[i] <= '0;
      end
    end else begin
      v1_r <= v0_r;
      if (v0_r) begin
        for (int c = 0; c < CH; c++) begin
          for (int t = 0; t < 9; t++) begin
            prod_r[c*9+t] <= win_r[c][t/3][t%3] * wt_r[c*9+t];
          end
        end
      end
    end
  end

  // Accumulate all products; the accumulator is wide enough to never overflow.
  always_comb begin
    acc_s = '0;
    for (int i = 0; i < CH*9; i++) begin
      acc_s = acc_s + $signed({{(ACC_W-PW){prod_r[i][PW-1]}}, prod_r[i]});
    end
    sat_s = round_sat(acc_s);
  end

  // Stage 2: registered result, per-frame output count and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_r     <= '0;
      dout_valid_r <= 1'b0;
      done_r       <= 1'b0;
      out_cnt_r    <= '0;
    end else begin
      dout_valid_r <= v1_r;
      done_r       <= v1_r && (out_cnt_r == OUT_LAST);
      if (start_acc_s) begin
        out_cnt_r <= '0;
      end else if (v1_r) begin
        out_cnt_r <= out_cnt_r + OW'(1);
      end
      if (v1_r) begin
        result_r <= sat_s[DATA_W-1:0];
      end
    end
  end

  assign bus.result     = result_r;
  assign bus.dout_valid = dout_valid_r;
  assign bus.done       = done_r;
  assign bus.busy       = busy_r;
endmodule

// File: tb/tb_conv_control_mc.sv
// Randomised scoreboard bench for conv_control_mc: a direct-sum reference model
// fills an expectation queue, an independent monitor pops and checks every output.
module tb_conv_control_mc;
  localparam int CH   = 2;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int DW   = 16;
  localparam int FRAC = 8;
  localparam int NOUT = (W - 2) * (H - 2);

  typedef struct {
    logic [DW-1:0] val;
    int            cyc;
    bit            last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pix_a [CH][H*W];
  int   wt_a  [CH][9];
  exp_t exp_q [$];
  exp_t mon_e;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  conv_control_mc_if #(.CH(CH), .DATA_W(DW)) bus ();

  conv_control_mc #(.CH(CH), .IMG_W(W), .IMG_H(H), .DATA_W(DW), .FRAC(FRAC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [DW-1:0] ref_out(input int y, input int x);
    longint acc;
    longint r;
    logic [63:0] rb;
    acc = 0;
    for (int c = 0; c < CH; c++)
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          acc += longint'(pix_a[c][(y-2+i)*W + (x-2+j)]) * longint'(wt_a[c][3*i+j]);
    r = (acc + (longint'(1) <<< (FRAC-1))) >>> FRAC;
    if (r > longint'((1 << (DW-1)) - 1)) r = longint'((1 << (DW-1)) - 1);
    if (r < -longint'(1 << (DW-1)))      r = -longint'(1 << (DW-1));
    rb = r;
    return rb[DW-1:0];
  endfunction

  function automatic int sx(input int v);
    logic [DW-1:0] b;
    b = DW'(v);
    return int'($signed(b));
  endfunction

  task automatic fill(input int pv, input int wv);
    for (int c = 0; c < CH; c++) begin
      for (int i = 0; i < H*W; i++) pix_a[c][i] = sx(pv);
      for (int t = 0; t < 9; t++)   wt_a[c][t]  = sx(wv);
    end
  endtask

  task automatic fill_ramp();
    fill(0, 0);
    for (int i = 0; i < H*W; i++) pix_a[0][i] = i << 8;
    wt_a[0][4] = 16'h0100;
  endtask

  task automatic fill_random();
    for (int c = 0; c < CH; c++) begin
      for (int i = 0; i < H*W; i++) pix_a[c][i] = sx(int'($urandom_range(0, 65535)));
      for (int t = 0; t < 9; t++)   wt_a[c][t]  = int'($urandom_range(0, 1023)) - 512;
    end
  endtask

  task automatic start_frame();
    for (int c = 0; c < CH; c++)
      for (int t = 0; t < 9; t++)
        bus.weight[(c*9+t)*DW +: DW] = DW'(wt_a[c][t]);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic drive_beat(input int i, input int gap, input bit poke);
    repeat (gap) begin
      bus.din_valid = 1'b0;
      @(posedge clk); #1;
    end
    for (int c = 0; c < CH; c++) bus.din[c*DW +: DW] = DW'(pix_a[c][i]);
    bus.din_valid = 1'b1;
    if (poke) begin
      bus.start  = 1'b1;
      bus.weight = ~bus.weight;
    end
    @(posedge clk); #1;
    bus.din_valid = 1'b0;
    bus.start     = 1'b0;
  endtask

  // gap_mode 0: streaming, 1: every other cycle plus a 5-cycle stall mid-row, 2: random gaps
  task automatic send_frame(input int gap_mode, input bit poke);
    int   k;
    int   gap;
    exp_t e;
    k = 0;
    for (int i = 0; i < H*W; i++) begin
      gap = 0;
      if (gap_mode == 1) gap = (i == 6) ? 6 : 1;
      if (gap_mode == 2) gap = int'($urandom_range(0, 2));
      drive_beat(i, gap, poke && (i == 5));
      if ((i / W) >= 2 && (i % W) >= 2) begin
        e.val  = ref_out(i / W, i % W);
        e.cyc  = cyc + 2;
        e.last = (k == NOUT - 1);
        exp_q.push_back(e);
        k++;
      end
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.done) begin
      errors++;
      $display("FAIL done_timeout waited %0d cycles", n);
    end else begin
      checks++;
      if (bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_at_done got %b want 1", bus.busy);
      end
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL busy_after_done got %b want 0", bus.busy);
      end
    end
  endtask

  task automatic run_frame(input int gap_mode, input bit poke);
    start_frame();
    send_frame(gap_mode, poke);
    wait_done();
  endtask

  // Monitor: every dout_valid must match the head of the expectation queue
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.dout_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_dout result=%h at cycle %0d", bus.result, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (bus.result !== mon_e.val) begin
            errors++;
            $display("FAIL result got %h want %h", bus.result, mon_e.val);
          end
          checks++;
          if (cyc != mon_e.cyc) begin
            errors++;
            $display("FAIL latency got cycle %0d want %0d", cyc, mon_e.cyc);
          end
          checks++;
          if (bus.done !== mon_e.last) begin
            errors++;
            $display("FAIL done_flag got %b want %b", bus.done, mon_e.last);
          end
        end
      end else if (bus.done) begin
        checks++;
        errors++;
        $display("FAIL done_without_valid got done=1 want 0");
      end
    end
  end

  task automatic check_quiet(input string tag);
    checks++;
    if (bus.result !== '0 || bus.dout_valid !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s got result=%h dv=%b done=%b busy=%b want all 0",
               tag, bus.result, bus.dout_valid, bus.done, bus.busy);
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.weight    = '0;
    bus.din_valid = 1'b0;
    bus.din       = '0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset_state");
    rst = 1'b0;
    @(posedge clk); #1;

    fill(16'h0100, 16'h0100);          run_frame(0, 1'b0);
    fill_ramp();                       run_frame(0, 1'b0);
    fill_ramp();                       run_frame(1, 1'b0);
    fill(16'h7FFF, 16'h7FFF);          run_frame(0, 1'b0);
    fill(16'h8000, 16'h7FFF);          run_frame(2, 1'b0);
    fill(16'h0001, 0); wt_a[0][0] = 16'h0080; run_frame(0, 1'b0);
    fill(16'h0001, 0); wt_a[0][0] = 16'h007F; run_frame(0, 1'b0);

    // Abort mid-frame: nothing from the aborted frame may appear
    fill(16'h0100, 16'h0100);
    start_frame();
    for (int i = 0; i < 7; i++) drive_beat(i, 0, 1'b0);
    rst = 1'b1;
    #1;
    check_quiet("reset_mid_frame");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    fill(16'h0100, 16'h0100);          run_frame(0, 1'b0);

    // start while busy must not disturb the latched weights
    fill_ramp();                       run_frame(0, 1'b1);

    // din_valid while idle must produce nothing and not advance counters
    for (int i = 0; i < 5; i++) drive_beat(i, 0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    fill(16'h0100, 16'h0100);          run_frame(0, 1'b0);

    for (int f = 0; f < 6; f++) begin
      fill_random();
      run_frame(int'($urandom_range(0, 2)), 1'b0);
    end

    repeat (4) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_control_mc.md
Name: conv_control_mc

Overview:
Parametrised successor to the two-channel streaming 3x3 convolution controller. It accepts a raster-ordered input frame with CH channels, one pixel per channel per accepted beat, and keeps per-channel line buffers so the frame is sent exactly once. It computes the valid-mode 3x3 convolution summed across all channels and streams (IMG_W-2)*(IMG_H-2) results. New behaviour over the previous generation:
- channel count and frame size are parameters;
- din_valid may stall (gaps are allowed);
- arithmetic is signed fixed-point with rounding and saturation;
- a busy output is provided.

Parameters:
CH, 2, number of input channels (1..8)
IMG_W, 4, frame width in pixels (>=3)
IMG_H, 4, frame height in pixels (>=3)
DATA_W, 16, pixel/weight/result width, signed two's complement
FRAC, 8, fractional bits of the Q format (1..DATA_W-1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle pulse: latch weights, begin frame
weight  in  CH*9*DATA_W  channel c, tap t (t = 3*row+col) at bits [(c*9+t)*DATA_W +: DATA_W]; sampled only on accepted start
din_valid  in  1  din carries one pixel per channel this cycle
din  in  CH*DATA_W  channel c pixel at [c*DATA_W +: DATA_W]
result  out  DATA_W  convolution output, Q(DATA_W-FRAC).FRAC
dout_valid  out  1  result valid this cycle, single-cycle per result
done  out  1  pulses with the last dout_valid of a frame
busy  out  1  high from accepted start until the cycle after done

Behaviour:
- Reset: all outputs 0; state IDLE; pixel counters, line buffers, window registers and pipeline valids cleared. Asserting rst mid-frame aborts the frame; no further dout_valid or done is produced for it.
- States:
  - IDLE: start=1 latches weight, clears row/col counters, goes to LOAD, busy=1 next cycle. din_valid in IDLE is ignored.
  - LOAD: each din_valid beat is one pixel at (row, col). col wraps to 0 at IMG_W-1 and row increments. Cycles without din_valid hold all state.
  - After beat (IMG_H-1, IMG_W-1) is accepted, go to DRAIN. Further din_valid is ignored until IDLE.
  - DRAIN: wait for the pipeline to empty; the cycle done is asserted, return to IDLE. busy drops the following cycle.
- start is ignored whenever busy=1.
- Line buffers: two rows of IMG_W per channel plus a 3x3 window shift register per channel. Both advance only on accepted beats.
- A window is complete when the accepted pixel has row>=2 and col>=2. Its output is the window whose bottom-right pixel is that pixel. Outputs therefore appear in raster order.
- Arithmetic:
  - products p = pixel*weight are full 2*DATA_W signed;
  - acc = sum of CH*9 products, width 2*DATA_W+ceil(log2(9*CH)), no overflow possible;
  - rounding: r = (acc + 2^(FRAC-1)) >>> FRAC (round half up);
  - saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Latency: fixed 2 cycles, independent of stalls.
  - Edge E accepts the completing pixel.
  - Edge E+1 registers the products.
  - Edge E+2 registers result with dout_valid=1.
- dout_valid is high for exactly one cycle per window. result holds its last value otherwise.
- done=1 in the same cycle as the ((IMG_W-2)*(IMG_H-2))-th dout_valid of the frame.
- Back-to-back frames: a start accepted the cycle after busy falls must work without residue from the previous frame.

Test Plan:
1. CH=2, 4x4, all weights 0x0100 (1.0), all pixels 0x0100:
   - 4 results of 0x1200 (18.0);
   - dout_valid on 4 cycles, done with the 4th;
   - busy falls one cycle after done.
2. Ramp: ch0 pixel = raster index<<8, ch1 = 0. Weights: ch0 center tap 0x0100, all others 0:
   - results 0x0500, 0x0600, 0x0900, 0x0A00 in order;
   - each dout_valid exactly 2 cycles after pixels 10, 11, 14, 15 are accepted.
3. Repeat scenario 2 with din_valid low on every other cycle and a 5-cycle gap mid-row:
   - identical result values and order;
   - dout_valid timing tracks accepted beats (+2).
4. Saturation: all pixels and weights 0x7FFF → every result 0x7FFF. Pixels 0x8000, weights 0x7FFF → every result 0x8000.
5. Rounding: single nonzero tap, pixel 0x0001, weight 0x0080:
   - acc = 0x80 rounds up, result 0x0001;
   - with weight 0x007F, result 0x0000.
6. Control robustness:
   - rst pulsed after 7 pixels: outputs zero immediately, no dout_valid or done;
   - then a full frame per scenario 1 produces correct results;
   - start pulsed while busy is ignored (weights unchanged);
   - din_valid sent in IDLE produces no output.
